// File: rtl/ex_muldiv.sv
// ex_muldiv: HI/LO register file for the EX stage with single-cycle MULT/MULTU,
// MTHI/MTLO writes and an optional 32-step restoring divider.
// Optional feature macro: OPENMIPS_DIV_EN. When it is defined, the divider FSM
// is built. When it is undefined, DIV/DIVU are no-ops and stall/done are 0.
//
// state | meaning
// IDLE  | accept MULT/MTHI/MTLO; launch DIV/DIVU (stall asserted combinationally)
// RUN   | one restoring step per cycle for 32 cycles, stall held high
// END   | done pulse, HI/LO commit at closing edge, presented DIV is not relaunched
module ex_muldiv (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_i_vld,
  input  logic [7:0]  ex_i_alu_op,
  input  logic [31:0] ex_i_reg0,
  input  logic [31:0] ex_i_reg1,
  input  logic        ex_i_flush,
  output logic        ex_o_stall,
  output logic [31:0] ex_o_hi,
  output logic [31:0] ex_o_lo,
  output logic        ex_o_done
);

  // MFHI (8'h10) and MFLO (8'h12) never touch state, so they need no decode.
  localparam logic [7:0] EXE_OP_MTHI  = 8'b0001_0001;
  localparam logic [7:0] EXE_OP_MTLO  = 8'b0001_0011;
  localparam logic [7:0] EXE_OP_MULT  = 8'b0001_1000;
  localparam logic [7:0] EXE_OP_MULTU = 8'b0001_1001;

  logic        idle;
  logic [63:0] prod_s;
  logic [63:0] prod_u;

  assign prod_s = {{32{ex_i_reg0[31]}}, ex_i_reg0} * {{32{ex_i_reg1[31]}}, ex_i_reg1};
  assign prod_u = {32'd0, ex_i_reg0} * {32'd0, ex_i_reg1};

`ifdef OPENMIPS_DIV_EN
  localparam logic [7:0] EXE_OP_DIV  = 8'b0001_1010;
  localparam logic [7:0] EXE_OP_DIVU = 8'b0001_1011;

  typedef enum logic [1:0] {IDLE, RUN, END} state_t;

  state_t      state;
  logic [4:0]  count;
  logic [31:0] rem;
  logic [31:0] quo;
  logic [31:0] dvs;
  logic        neg_q;
  logic        neg_r;
  logic        div_req;
  logic        is_signed;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [32:0] shifted;
  logic [32:0] trial;
  logic [31:0] quo_res;
  logic [31:0] rem_res;

  assign idle      = (state == IDLE);
  assign is_signed = (ex_i_alu_op == EXE_OP_DIV);
  assign div_req   = ex_i_vld && ((ex_i_alu_op == EXE_OP_DIV) || (ex_i_alu_op == EXE_OP_DIVU));
  assign abs_a     = (is_signed && ex_i_reg0[31]) ? -ex_i_reg0 : ex_i_reg0;
  assign abs_b     = (is_signed && ex_i_reg1[31]) ? -ex_i_reg1 : ex_i_reg1;
  assign shifted   = {rem, quo[31]};
  assign trial     = shifted - {1'b0, dvs};
  assign quo_res   = neg_q ? -quo : quo;
  assign rem_res   = neg_r ? -rem : rem;

  // Flush masks both handshake outputs in the cycle it is asserted.
  assign ex_o_stall = !ex_i_flush && ((idle && div_req) || (state == RUN));
  assign ex_o_done  = !ex_i_flush && (state == END);

  // Divider sequencing; operands are captured only on leaving IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= 5'd0;
      rem   <= 32'd0;
      quo   <= 32'd0;
      dvs   <= 32'd0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (ex_i_flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (div_req) begin
            count <= 5'd0;
            if (ex_i_reg1 == 32'd0) begin
              // Divide-by-zero result is preloaded so END commits it unchanged.
              quo   <= 32'hFFFF_FFFF;
              rem   <= ex_i_reg0;
              neg_q <= 1'b0;
              neg_r <= 1'b0;
              state <= END;
            end else begin
              quo   <= abs_a;
              rem   <= 32'd0;
              dvs   <= abs_b;
              neg_q <= is_signed && (ex_i_reg0[31] ^ ex_i_reg1[31]);
              neg_r <= is_signed && ex_i_reg0[31];
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (!trial[32]) begin
            rem <= trial[31:0];
            quo <= {quo[30:0], 1'b1};
          end else begin
            rem <= shifted[31:0];
            quo <= {quo[30:0], 1'b0};
          end
          count <= count + 5'd1;
          if (count == 5'd31) state <= END;
        end
        END:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
`else
  assign idle       = 1'b1;
  assign ex_o_stall = 1'b0;
  assign ex_o_done  = 1'b0;
`endif

  // HI/LO writes: single-cycle ops only while idle, divide result at END.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_o_hi <= 32'd0;
      ex_o_lo <= 32'd0;
    end else if (!ex_i_flush) begin
      if (idle && ex_i_vld) begin
        case (ex_i_alu_op)
          EXE_OP_MULT:  {ex_o_hi, ex_o_lo} <= prod_s;
          EXE_OP_MULTU: {ex_o_hi, ex_o_lo} <= prod_u;
          EXE_OP_MTHI:  ex_o_hi <= ex_i_reg0;
          EXE_OP_MTLO:  ex_o_lo <= ex_i_reg0;
          default: ;
        endcase
      end
`ifdef OPENMIPS_DIV_EN
      if (state == END) begin
        ex_o_hi <= rem_res;
        ex_o_lo <= quo_res;
      end
`endif
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed checks of ex_muldiv. Divider checks are built when
// OPENMIPS_DIV_EN is defined; otherwise the DIV-as-no-op behaviour is checked.
module tb_ex_muldiv;

  localparam logic [7:0] OP_MFHI  = 8'h10;
  localparam logic [7:0] OP_MTHI  = 8'h11;
  localparam logic [7:0] OP_MTLO  = 8'h13;
  localparam logic [7:0] OP_MULT  = 8'h18;
  localparam logic [7:0] OP_MULTU = 8'h19;
  localparam logic [7:0] OP_DIV   = 8'h1A;
  localparam logic [7:0] OP_DIVU  = 8'h1B;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vld = 1'b0;
  logic        flush = 1'b0;
  logic [7:0]  op = 8'd0;
  logic [31:0] r0 = 32'd0;
  logic [31:0] r1 = 32'd0;
  logic        stall;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  ex_muldiv dut (
    .clk         (clk),
    .rst         (rst),
    .ex_i_vld    (vld),
    .ex_i_alu_op (op),
    .ex_i_reg0   (r0),
    .ex_i_reg1   (r1),
    .ex_i_flush  (flush),
    .ex_o_stall  (stall),
    .ex_o_hi     (hi),
    .ex_o_lo     (lo),
    .ex_o_done   (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic present(input logic [7:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    vld = 1'b1; op = o; r0 = a; r1 = b;
    #1;
  endtask

  task automatic quiet;
    @(negedge clk);
    vld = 1'b0; op = 8'd0; flush = 1'b0; rst = 1'b0;
    #1;
  endtask

  task automatic set_hilo(input logic [31:0] h, input logic [31:0] l);
    present(OP_MTHI, h, 32'd0);
    present(OP_MTLO, l, 32'd0);
    quiet();
    chk("set_hi", hi, h);
    chk("set_lo", lo, l);
  endtask

`ifdef OPENMIPS_DIV_EN
  task automatic run_div(input string tag, input logic [7:0] o, input logic [31:0] a,
                         input logic [31:0] b, input int exp_stall,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                         input logic [31:0] old_hi, input logic [31:0] old_lo,
                         input bit scramble);
    int n = 0;
    int early_done = 0;
    present(o, a, b);
    while (stall && n < 200) begin
      n++;
      if (done) early_done++;
      @(negedge clk);
      if (scramble) begin r0 = $urandom; r1 = $urandom; end
      #1;
    end
    chk({tag, "_stall_cycles"}, n, exp_stall);
    chk({tag, "_done_during_stall"}, early_done, 0);
    chk({tag, "_done_in_end"}, 32'(done), 32'd1);
    chk({tag, "_hi_held_in_end"}, hi, old_hi);
    chk({tag, "_lo_held_in_end"}, lo, old_lo);
    quiet();
    chk({tag, "_hi"}, hi, exp_hi);
    chk({tag, "_lo"}, lo, exp_lo);
    chk({tag, "_no_relaunch_stall"}, 32'(stall), 32'd0);
    chk({tag, "_done_cleared"}, 32'(done), 32'd0);
  endtask

  task automatic abort_div(input bit use_rst);
    int st = 0;
    int dn = 0;
    set_hilo(32'h0000_000A, 32'h0000_000B);
    present(OP_DIVU, 32'h8000_0000, 32'd3);
    repeat (10) @(negedge clk);
    if (use_rst) rst = 1'b1;
    else flush = 1'b1;
    #1;
    if (!use_rst) begin
      chk("flush_stall_low", 32'(stall), 32'd0);
      chk("flush_done_low", 32'(done), 32'd0);
    end
    quiet();
    repeat (40) begin
      if (stall) st++;
      if (done) dn++;
      @(negedge clk);
      #1;
    end
    chk(use_rst ? "rst_abort_stall" : "flush_abort_stall", st, 0);
    chk(use_rst ? "rst_abort_done" : "flush_abort_done", dn, 0);
    chk(use_rst ? "rst_abort_hi" : "flush_abort_hi", hi, use_rst ? 32'd0 : 32'h0000_000A);
    chk(use_rst ? "rst_abort_lo" : "flush_abort_lo", lo, use_rst ? 32'd0 : 32'h0000_000B);
  endtask
`endif

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    chk("reset_stall", 32'(stall), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    quiet();

    set_hilo(32'h1234_5678, 32'h9ABC_DEF0);

    present(OP_MULT, 32'hFFFF_FFFE, 32'h0000_0003);
    chk("mult_stall", 32'(stall), 32'd0);
    quiet();
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);
    chk("mult_stall_after", 32'(stall), 32'd0);

    present(OP_MULTU, 32'hFFFF_FFFE, 32'h0000_0003);
    quiet();
    chk("multu_hi", hi, 32'h0000_0002);
    chk("multu_lo", lo, 32'hFFFF_FFFA);

    present(OP_MFHI, 32'h1111_1111, 32'h2222_2222);
    quiet();
    chk("mfhi_hi_unchanged", hi, 32'h0000_0002);
    chk("mfhi_lo_unchanged", lo, 32'hFFFF_FFFA);

    @(negedge clk);
    vld = 1'b0; op = OP_MTHI; r0 = 32'hDEAD_BEEF;
    quiet();
    chk("novld_hi_unchanged", hi, 32'h0000_0002);

    present(OP_MULT, 32'd7, 32'd9);
    flush = 1'b1;
    #1;
    chk("flush_mult_stall", 32'(stall), 32'd0);
    quiet();
    chk("flush_mult_hi", hi, 32'h0000_0002);
    chk("flush_mult_lo", lo, 32'hFFFF_FFFA);

`ifdef OPENMIPS_DIV_EN
    set_hilo(32'h0000_0111, 32'h0000_0222);
    run_div("div_neg7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 33,
            32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h0000_0111, 32'h0000_0222, 1'b1);
    run_div("divu_100_0", OP_DIVU, 32'd100, 32'd0, 1,
            32'h0000_0064, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_div("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33,
            32'h0000_0000, 32'h8000_0000, 32'h0000_0064, 32'hFFFF_FFFF, 1'b0);
    run_div("div_7_neg2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 33,
            32'h0000_0001, 32'hFFFF_FFFD, 32'h0000_0000, 32'h8000_0000, 1'b0);
    run_div("divu_100_7", OP_DIVU, 32'd100, 32'd7, 33,
            32'h0000_0002, 32'h0000_000E, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
    abort_div(1'b0);
    abort_div(1'b1);
`else
    begin
      int st = 0;
      int dn = 0;
      set_hilo(32'h0000_0055, 32'h0000_0066);
      present(OP_DIV, 32'd10, 32'd2);
      repeat (40) begin
        if (stall) st++;
        if (done) dn++;
        @(negedge clk);
        #1;
      end
      quiet();
      chk("nodiv_stall", st, 0);
      chk("nodiv_done", dn, 0);
      chk("nodiv_hi", hi, 32'h0000_0055);
      chk("nodiv_lo", lo, 32'h0000_0066);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 SHALL provide one clock; reset is synchronous and active-high.
REQ-002 SHALL have ports:
  clk            in   1   clock, all state on rising edge
  rst            in   1   synchronous active-high reset
  ex_i_vld       in   1   ID/EX operation valid
  ex_i_alu_op    in   8   operation code, EXE_OP_* encoding
  ex_i_reg0      in   32  rs operand (dividend / multiplicand / MTHI-MTLO source)
  ex_i_reg1      in   32  rt operand (divisor / multiplier)
  ex_i_flush     in   1   cancel any in-flight operation
  ex_o_stall     out  1   hold IF/ID/EX; ID keeps presenting same op
  ex_o_hi        out  32  architectural HI register
  ex_o_lo        out  32  architectural LO register
  ex_o_done      out  1   one-cycle pulse, divide result committed

Function
REQ-003 SHALL act only on ex_i_alu_op in {EXE_OP_MULT, MULTU, DIV, DIVU, MTHI, MTLO} with ex_i_vld=1; all other ops or ex_i_vld=0 leave state unchanged.
REQ-004 MULT/MULTU SHALL write the 64-bit product, signed or unsigned, as {HI,LO} at the clock edge ending the presentation cycle; no stall.
REQ-005 MTHI SHALL load HI <= ex_i_reg0 and MTLO SHALL load LO <= ex_i_reg0 at the same edge; the other register is unchanged.
REQ-006 MFHI/MFLO SHALL NOT change state; consumers read ex_o_hi/ex_o_lo, which reflect every write from the following cycle.
REQ-007 Divider FSM SHALL have states IDLE, RUN, END.
REQ-008 IDLE + DIV/DIVU + divisor!=0: ex_o_stall=1 combinationally; next state RUN, 5-bit count=0.
REQ-009 RUN SHALL perform one radix-2 restoring step per cycle on absolute values, with ex_o_stall=1; after 32 RUN cycles go to END.
REQ-010 IDLE + DIV/DIVU + divisor==0: ex_o_stall=1 for one cycle, next state END; result LO=0xFFFFFFFF, HI=ex_i_reg0.
REQ-011 END SHALL drive ex_o_stall=0 and ex_o_done=1, commit HI=remainder and LO=quotient at its closing edge, and return to IDLE; the DIV still presented during END SHALL NOT relaunch.
REQ-012 Signed DIV: negate quotient when operand signs differ; remainder takes the dividend's sign; 0x80000000/0xFFFFFFFF yields LO=0x80000000, HI=0.
REQ-013 Total stall for a non-zero divide SHALL be 33 cycles; HI/LO update 34 cycles after first presentation.
REQ-014 Operands SHALL be latched on IDLE->RUN; input changes during RUN are ignored.
REQ-015 ex_i_flush=1 SHALL take priority over everything: FSM to IDLE next cycle, no HI/LO write, ex_o_done=0, ex_o_stall=0 in that cycle, and no new op launched in that cycle.
REQ-016 MTHI/MTLO/MULT SHALL NOT arrive during RUN; stall guarantees this, and the block ignores them if it happens.

Reset
REQ-017 rst=1 SHALL force state IDLE, count=0, HI=LO=0, ex_o_stall=0, ex_o_done=0 from the next cycle, aborting any divide with no commit.
REQ-018 rst SHALL override ex_i_flush and any op.

Configuration
REQ-019 Macro OPENMIPS_DIV_EN defined: divider FSM present as above.
REQ-020 Macro undefined: no FSM; DIV/DIVU SHALL be treated as no-ops; ex_o_stall and ex_o_done SHALL be tied 0; MULT/MTHI/MTLO behaviour unchanged.

Verification
REQ-021 MULT 0xFFFFFFFE,0x00000003 -> next cycle HI=0xFFFFFFFF, LO=0xFFFFFFFA; stall never high.
REQ-022 MULTU 0xFFFFFFFE,0x00000003 -> HI=0x00000002, LO=0xFFFFFFFA.
REQ-023 DIV 0xFFFFFFF9 (-7),0x00000002 -> stall high exactly 33 cycles, done pulse in END, LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-024 DIVU 100,0 -> stall 1 cycle, then LO=0xFFFFFFFF, HI=0x00000064.
REQ-025 DIVU 0x80000000,3 with flush at RUN cycle 10 -> HI/LO keep prior values, stall low in flush cycle, done never pulses; same test with rst instead -> HI=LO=0.
REQ-026 OPENMIPS_DIV_EN undefined, DIV 10,2 after MTHI 0x55 -> HI stays 0x55, stall stays 0.
